// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port among NUM_REQ requesters,
// with a fixed-length access window and an idle-timeout low-power state.
module mem_port_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int ADDR_W        = 4,
   parameter int DATA_W        = 8,
   parameter int ACCESS_CYCLES = 2,
   parameter int IDLE_TIMEOUT  = 10
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ-1:0]         rw,
   input  logic [NUM_REQ*ADDR_W-1:0]  addr,
   input  logic [NUM_REQ*DATA_W-1:0]  wdata,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [NUM_REQ-1:0]         done,
   output logic [DATA_W-1:0]          rdata,
   output logic                       mem_en,
   output logic                       mem_we,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic [DATA_W-1:0]          mem_wdata,
   input  logic [DATA_W-1:0]          mem_rdata,
   output logic                       low_power
);
   localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
   typedef enum logic [1:0] {IDLE, ACCESS, DONE, LOW_POWER} state_t;
   state_t r_state, w_next;
   logic [IW-1:0] r_ptr, r_win, w_win, w_k;
   logic [7:0] r_idle_cnt;
   logic [3:0] r_acc_cnt;
   logic r_rw;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata, r_rdata;
   logic [NUM_REQ-1:0] r_gnt;
   logic w_any, w_last;
   assign w_any  = |req;
   assign w_last = r_acc_cnt == 4'(ACCESS_CYCLES - 1);
   assign gnt    = r_gnt;
   assign rdata  = r_rdata;
   // Scan from the farthest offset back toward ptr so the nearest requester wins last.
   always_comb begin
      w_win = '0;
      w_k   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         w_k = IW'((int'(r_ptr) + i) % NUM_REQ);
         if (req[w_k]) w_win = w_k;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end
   always_comb begin
      w_next    = r_state;
      done      = '0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      low_power = 1'b0;
      case (r_state)
         IDLE: w_next = w_any ? ACCESS : (r_idle_cnt == 8'(IDLE_TIMEOUT - 1)) ? LOW_POWER : IDLE;
         ACCESS: begin
            mem_en    = 1'b1;
            mem_we    = r_rw;
            mem_addr  = r_addr;
            mem_wdata = r_wdata;
            w_next    = w_last ? DONE : ACCESS;
         end
         DONE: begin
            done[r_win] = 1'b1;
            w_next      = IDLE;
         end
         default: begin
            low_power = 1'b1;
            w_next    = w_any ? IDLE : LOW_POWER;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr      <= '0;
         r_win      <= '0;
         r_idle_cnt <= '0;
         r_acc_cnt  <= '0;
         r_rw       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rdata    <= '0;
         r_gnt      <= '0;
      end else begin
         r_acc_cnt  <= (r_state == ACCESS) ? r_acc_cnt + 4'd1 : 4'd0;
         r_idle_cnt <= (r_state == IDLE && !w_any) ? r_idle_cnt + 8'd1 : 8'd0;
         if (r_state == IDLE && w_any) begin
            r_win   <= w_win;
            r_rw    <= rw[w_win];
            r_addr  <= addr[w_win*ADDR_W +: ADDR_W];
            r_wdata <= wdata[w_win*DATA_W +: DATA_W];
            r_gnt   <= NUM_REQ'(1) << w_win;
         end
         if (r_state == ACCESS && w_last && !r_rw) r_rdata <= mem_rdata;
         if (r_state == DONE) begin
            r_gnt <= '0;
            r_ptr <= (r_win == IW'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a done-event scoreboard for mem_port_arbiter.
module tb_mem_port_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req, rw, gnt, done;
   logic [15:0] addr;
   logic [31:0] wdata;
   logic [7:0]  rdata, mem_wdata, mem_rdata;
   logic        mem_en, mem_we, low_power;
   logic [3:0]  mem_addr;
   logic [7:0]  mem [16];
   typedef struct {logic [3:0] dn; logic rd; logic [7:0] rdata;} exp_t;
   exp_t sb [$];
   int n_tests = 0;
   int n_fail  = 0;

   mem_port_arbiter dut (
      .clk(clk), .rst(rst), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
      .gnt(gnt), .done(done), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .low_power(low_power)
   );

   always #5 clk = ~clk;
   assign mem_rdata = mem[mem_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   always @(negedge clk) begin
      chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
      if (done != 4'b0) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_unexpected: got %b expected none", done);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("done_vec", 32'(done), 32'(e.dn));
            chk("done_gnt", 32'(gnt), 32'(e.dn));
            if (e.rd) chk("done_rdata", 32'(rdata), 32'(e.rdata));
         end
      end
   end

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'(8'h10 + i);
      mem[7] = 8'h3C;
      mem[1] = 8'h77;
      rst = 1'b1; req = '0; rw = '0; addr = '0; wdata = '0;
      cyc(2);
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_rdata", 32'(rdata), 0);
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_wdata", 32'(mem_wdata), 0);
      chk("rst_low_power", 32'(low_power), 0);
      rst = 1'b0;
      // single write from requester 0
      req = 4'b0001; rw = 4'b0001; addr[3:0] = 4'd3; wdata[7:0] = 8'hA5;
      sb.push_back('{4'b0001, 1'b0, 8'h00});
      for (int c = 1; c <= 2; c++) begin
         cyc(1);
         chk("wr_gnt", 32'(gnt), 32'b0001);
         chk("wr_mem_en", 32'(mem_en), 1);
         chk("wr_mem_we", 32'(mem_we), 1);
         chk("wr_mem_addr", 32'(mem_addr), 3);
         chk("wr_mem_wdata", 32'(mem_wdata), 32'hA5);
      end
      cyc(1);
      chk("wr_done_cycle", 32'(done), 32'b0001);
      chk("wr_done_mem_en", 32'(mem_en), 0);
      chk("wr_done_mem_addr", 32'(mem_addr), 0);
      chk("wr_done_gnt", 32'(gnt), 32'b0001);
      req = '0;
      cyc(1);
      chk("wr_idle_gnt", 32'(gnt), 0);
      // single read from requester 2 (ptr=1 now)
      req = 4'b0100; rw = '0; addr[11:8] = 4'd7;
      sb.push_back('{4'b0100, 1'b1, 8'h3C});
      cyc(1);
      chk("rd_gnt", 32'(gnt), 32'b0100);
      chk("rd_mem_we", 32'(mem_we), 0);
      chk("rd_mem_addr", 32'(mem_addr), 7);
      cyc(2);
      chk("rd_done_rdata", 32'(rdata), 32'h3C);
      req = '0;
      cyc(2);
      chk("rd_hold_rdata", 32'(rdata), 32'h3C);
      // contention after reset: 0,1,2,3,0
      rst = 1'b1;
      cyc(1);
      rst = 1'b0; req = 4'b1111; rw = '0; addr = 16'h4321;
      sb.push_back('{4'b0001, 1'b0, 8'h00});
      sb.push_back('{4'b0010, 1'b0, 8'h00});
      sb.push_back('{4'b0100, 1'b0, 8'h00});
      sb.push_back('{4'b1000, 1'b0, 8'h00});
      sb.push_back('{4'b0001, 1'b0, 8'h00});
      for (int g = 0; g < 5; g++) begin
         cyc(1);
         chk("rr_gnt", 32'(gnt), 32'(4'b0001 << (g % 4)));
         cyc(2);
         if (g == 4) req = '0;
         cyc(1);
      end
      // reset in the 2nd ACCESS cycle of a requester-2 write (ptr=1)
      req = 4'b0100; rw = 4'b0100; addr[11:8] = 4'd4; wdata[23:16] = 8'h99;
      cyc(2);
      chk("abort_mem_en", 32'(mem_en), 1);
      rst = 1'b1; req = '0;
      cyc(1);
      chk("abort_done", 32'(done), 0);
      chk("abort_gnt", 32'(gnt), 0);
      chk("abort_mem_en_off", 32'(mem_en), 0);
      chk("abort_mem_we", 32'(mem_we), 0);
      chk("abort_mem_addr", 32'(mem_addr), 0);
      chk("abort_mem_wdata", 32'(mem_wdata), 0);
      chk("abort_rdata", 32'(rdata), 0);
      chk("abort_low_power", 32'(low_power), 0);
      rst = 1'b0;
      // ptr must be back at 0: req 1001 grants 0
      req = 4'b1001; rw = '0;
      sb.push_back('{4'b0001, 1'b0, 8'h00});
      cyc(1);
      chk("ptr_after_reset", 32'(gnt), 32'b0001);
      cyc(2);
      req = '0;
      cyc(1);
      // requester 3 drops its request and changes inputs mid-access
      req = 4'b1000; rw = 4'b1000; addr[15:12] = 4'd5; wdata[31:24] = 8'h5A;
      sb.push_back('{4'b1000, 1'b0, 8'h00});
      cyc(1);
      chk("drop_gnt", 32'(gnt), 32'b1000);
      req = '0; rw = '0; addr[15:12] = 4'd9; wdata[31:24] = 8'h00;
      cyc(1);
      chk("drop_mem_addr", 32'(mem_addr), 5);
      chk("drop_mem_we", 32'(mem_we), 1);
      chk("drop_mem_wdata", 32'(mem_wdata), 32'h5A);
      cyc(1);
      chk("drop_done", 32'(done), 32'b1000);
      // idle timeout: IDLE from next cycle, 10 request-free cycles then LOW_POWER
      cyc(10);
      chk("lp_not_yet", 32'(low_power), 0);
      cyc(1);
      chk("lp_enter", 32'(low_power), 1);
      chk("lp_gnt", 32'(gnt), 0);
      chk("lp_done", 32'(done), 0);
      chk("lp_mem_en", 32'(mem_en), 0);
      chk("lp_mem_we", 32'(mem_we), 0);
      cyc(1);
      chk("lp_stay", 32'(low_power), 1);
      req = 4'b0010; rw = '0; addr[7:4] = 4'd1;
      sb.push_back('{4'b0010, 1'b1, 8'h77});
      cyc(1);
      chk("wake_low_power", 32'(low_power), 0);
      chk("wake_gnt_idle", 32'(gnt), 0);
      cyc(1);
      chk("wake_gnt", 32'(gnt), 32'b0010);
      chk("wake_mem_en", 32'(mem_en), 1);
      cyc(2);
      req = '0;
      cyc(2);
      chk("sb_drained", 32'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
